// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving a single gate-level add cell
// Operands are consumed LSB first over WIDTH cycles; sum/cout update only on entry to DONE.

module serial_half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    xor g_sum (s, x, y);
    and g_carry (c, x, y);
endmodule

module serial_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    serial_half_adder u_ha0 (.x(a),  .y(b),   .s(s1), .c(c1));
    serial_half_adder u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));
    or g_cout (cout, c1, c2);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cell_s;
    logic             cell_cout;
    logic             last_bit;

    serial_add_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign last_bit = (cnt == LAST);

    // New bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_s_one
            assign s_nxt = cell_s;
        end else begin : g_s_many
            assign s_nxt = {cell_s, s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_nxt;
                    carry <= cell_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= s_nxt;
                        cout <= cell_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
